// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
//   Two requesters share one overlapping 3-bit serial sequence detector. A
//   round-robin arbiter picks a winner in IDLE. The winner's word is shifted
//   MSB-first through a 3-bit history and compared with the winner's pattern.
//   The hit count is then reported with a one-cycle done pulse.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   req[1:0]   : level requests, held until granted
//   data0/1    : DATA_W-bit words of requester 0/1
//   pat0/1     : 3-bit patterns, first-received bit at [2]
//   gnt[1:0]   : one-hot one-cycle grant pulse
//   busy       : high whenever not in IDLE
//   det        : registered detect flag, high the cycle after a matching shift
//   done       : one-cycle completion pulse (REPORT)
//   done_id    : requester served, held until the next done
//   match_cnt  : hit count, held until the next done
module seq_detect_scheduler #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [2:0]        pat0,
  input  logic [2:0]        pat1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              det,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_word;
  logic [2:0]          r_pat;
  logic [2:0]          r_hist;
  logic [BCNT_W-1:0]   r_bitcnt;
  logic [CNT_W-1:0]    r_hits;
  logic                r_id;
  logic                r_ptr;

  logic                w_winner;
  logic [2:0]          w_hist_nxt;
  logic [BCNT_W-1:0]   w_bitcnt_nxt;
  logic                w_hit;
  logic                w_last;

  // Arbitration and next-window evaluation for the shift happening this cycle.
  always_comb begin
    w_winner     = r_ptr;
    if (req == 2'b01) w_winner = 1'b0;
    if (req == 2'b10) w_winner = 1'b1;
    w_hist_nxt   = {r_hist[1:0], r_word[DATA_W-1]};
    w_bitcnt_nxt = r_bitcnt + BCNT_W'(1);
    // A window only exists once three bits are in the history.
    w_hit        = (w_bitcnt_nxt >= BCNT_W'(3)) && (w_hist_nxt == r_pat);
    w_last       = (r_bitcnt == BCNT_W'(DATA_W - 1));
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_word    <= '0;
      r_pat     <= '0;
      r_hist    <= '0;
      r_bitcnt  <= '0;
      r_hits    <= '0;
      r_id      <= 1'b0;
      r_ptr     <= 1'b0;
      gnt       <= '0;
      busy      <= 1'b0;
      det       <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      match_cnt <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          det <= 1'b0;
          if (|req) begin
            r_state  <= S_SHIFT;
            busy     <= 1'b1;
            gnt      <= w_winner ? 2'b10 : 2'b01;
            r_ptr    <= ~w_winner;
            r_id     <= w_winner;
            r_word   <= w_winner ? data1 : data0;
            r_pat    <= w_winner ? pat1 : pat0;
            r_hist   <= '0;
            r_bitcnt <= '0;
            r_hits   <= '0;
          end
        end
        S_SHIFT: begin
          r_word   <= {r_word[DATA_W-2:0], 1'b0};
          r_hist   <= w_hist_nxt;
          r_bitcnt <= w_bitcnt_nxt;
          r_hits   <= r_hits + CNT_W'(w_hit);
          det      <= w_hit;
          // The final shift's hit must be included in the reported count.
          if (w_last) begin
            r_state   <= S_REPORT;
            done      <= 1'b1;
            match_cnt <= r_hits + CNT_W'(w_hit);
            done_id   <= r_id;
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          det     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          det     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler: a driver issues transactions and
// pushes predicted results; a monitor checks grants, busy, det and reports.
module tb_seq_detect_scheduler;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    req = '0;
  logic [DW-1:0] data0 = '0;
  logic [DW-1:0] data1 = '0;
  logic [2:0]    pat0 = '0;
  logic [2:0]    pat1 = '0;
  logic [1:0]    gnt;
  logic          busy;
  logic          det;
  logic          done;
  logic          done_id;
  logic [CW-1:0] match_cnt;

  seq_detect_scheduler #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .data0(data0), .data1(data1), .pat0(pat0), .pat1(pat1),
    .gnt(gnt), .busy(busy), .det(det), .done(done),
    .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit id;
    int cnt;
    int gnt_cyc;
    int done_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_ptr = 1'b0;
  int   free_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count overlapping pattern hits over the MSB-first bit stream.
  function automatic int ref_count(input logic [DW-1:0] w, input logic [2:0] p);
    int n = 0;
    bit b[DW];
    for (int i = 0; i < DW; i++) b[i] = w[DW-1-i];
    for (int i = 2; i < DW; i++)
      if (b[i-2] == p[2] && b[i-1] == p[1] && b[i] == p[0]) n++;
    return n;
  endfunction

  function automatic bit pick(input logic [1:0] rq, input bit ptr);
    if (rq == 2'b01) return 1'b0;
    if (rq == 2'b10) return 1'b1;
    return ptr;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic push_exp(input bit id, input int g);
    exp_t e;
    e.id       = id;
    e.cnt      = id ? ref_count(data1, pat1) : ref_count(data0, pat0);
    e.gnt_cyc  = g;
    e.done_cyc = g + DW;
    q.push_back(e);
  endtask

  task automatic txn(input logic [1:0] rq, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [2:0] p0, input logic [2:0] p1, input bit wig, output int g);
    bit w;
    wait_until(free_cyc);
    data0 = d0; data1 = d1; pat0 = p0; pat1 = p1; req = rq;
    w = pick(rq, m_ptr);
    g = cyc + 1;
    push_exp(w, g);
    m_ptr = ~w;
    free_cyc = g + DW + 1;
    step();
    if (wig) begin
      while (cyc < g + DW) begin
        req = 2'($urandom); data0 = DW'($urandom); data1 = DW'($urandom);
        pat0 = 3'($urandom); pat1 = 3'($urandom);
        step();
      end
    end
    req = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_det"}, det, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_id"}, done_id, 0);
    chk({tag, "_match_cnt"}, match_cnt, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    q.delete();
    m_ptr = 1'b0;
    step(); step();
    reset_n = 1'b1;
    free_cyc = cyc;
  endtask

  // Continuous req=11 for three grants; grants alternate starting from pointer.
  task automatic cont3();
    int c;
    bit w;
    wait_until(free_cyc);
    data0 = DW'($urandom); data1 = DW'($urandom);
    pat0 = 3'($urandom); pat1 = 3'($urandom);
    req = 2'b11;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      w = pick(2'b11, m_ptr);
      push_exp(w, c + 1 + k * (DW + 2));
      m_ptr = ~w;
    end
    free_cyc = c + 3 * (DW + 2);
    wait_until(c + 1 + 2 * (DW + 2));
    req = '0;
  endtask

  // Monitor: compares DUT outputs against the queue head.
  initial begin
    bit   in_flight = 1'b0;
    int   det_seen = 0;
    int   last_cnt = 0;
    int   last_id = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_flight = 1'b0; det_seen = 0; last_cnt = 0; last_id = 0;
        continue;
      end
      if (gnt != 2'b00) begin
        if (q.size() == 0) chk("unexpected_gnt", gnt, 0);
        else begin
          chk("gnt_onehot", gnt, q[0].id ? 2 : 1);
          chk("gnt_cycle", cyc, q[0].gnt_cyc);
        end
        in_flight = 1'b1;
        det_seen  = 0;
      end
      if (in_flight) det_seen += int'(det);
      else chk("det_idle", det, 0);
      chk("busy", busy, in_flight);
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", done, 0);
        else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("done_id", done_id, e.id);
          chk("match_cnt", match_cnt, e.cnt);
          chk("det_pulses", det_seen, e.cnt);
          last_cnt = e.cnt;
          last_id  = e.id;
        end
        in_flight = 1'b0;
      end else begin
        chk("held_match_cnt", match_cnt, last_cnt);
        chk("held_done_id", done_id, last_id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d expected=0", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    step(); step(); step();
    check_zero("reset");
    reset_n = 1'b1;
    free_cyc = cyc;

    txn(2'b01, 8'b10101101, DW'($urandom), 3'b101, 3'($urandom), 1'b0, g);
    txn(2'b10, DW'($urandom), 8'h00, 3'($urandom), 3'b000, 1'b0, g);
    txn(2'b10, DW'($urandom), 8'b11011011, 3'($urandom), 3'b110, 1'b0, g);
    txn(2'b01, 8'b01100000, DW'($urandom), 3'b101, 3'($urandom), 1'b0, g);

    wait_until(free_cyc);
    do_reset("idle_reset");
    cont3();

    // Abort during SHIFT cycle 4; the pointer had moved to 1 and must clear.
    txn(2'b01, DW'($urandom), DW'($urandom), 3'($urandom), 3'($urandom), 1'b0, g);
    wait_until(g + 3);
    do_reset("abort_reset");
    txn(2'b11, DW'($urandom), DW'($urandom), 3'($urandom), 3'($urandom), 1'b0, g);

    txn(2'b11, DW'($urandom), DW'($urandom), 3'($urandom), 3'($urandom), 1'b1, g);

    for (int i = 0; i < 40; i++) begin
      txn(2'($urandom_range(1, 3)), DW'($urandom), DW'($urandom),
          3'($urandom), 3'($urandom), 1'($urandom), g);
    end

    wait_until(free_cyc + 2);
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
# seq_detect_scheduler

Shares a single overlapping 3-bit sequence detector between two requesters. Each granted requester's parallel word is shifted MSB-first through the detector against a 3-bit pattern latched with the word. The block returns the number of pattern hits with a done pulse. It sits between the requesting blocks and the serial detect datapath, and provides arbitration, sequencing and reporting.

## Interface
- DATA_W, 8: word length in bits; legal range 3..15.
- CNT_W, 4: match-count width; must satisfy 2^CNT_W > DATA_W-2.

- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request; level, held until gnt.
- data0  in  DATA_W  word of requester 0.
- data1  in  DATA_W  word of requester 1.
- pat0  in  3  pattern of requester 0, first-received bit at [2].
- pat1  in  3  pattern of requester 1.
- gnt  out  2  one-hot, one-cycle grant pulse.
- busy  out  1  high in any state other than IDLE.
- det  out  1  Moore detect flag: high for the cycle after a shift completes a matching window.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester served; valid with done, held until the next done.
- match_cnt  out  CNT_W  hit count; valid with done, held until the next done.

## Operation
- FSM states: IDLE, SHIFT, REPORT.
  - IDLE -> SHIFT when any req bit is high.
  - SHIFT -> REPORT after DATA_W shifts.
  - REPORT -> IDLE unconditionally.
- Arbitration is round-robin with a 1-bit priority pointer.
  - Reset sets the pointer to 0, so requester 0 wins a tie.
  - After a grant to requester i, the pointer moves to the other requester.
  - A single active request is granted regardless of the pointer.
- On the IDLE->SHIFT edge the block:
  - latches data and pat of the winner;
  - clears the 3-bit history, the bit counter and the internal hit counter;
  - records the requester id.
- req is ignored outside IDLE. Requesters must hold data and pat stable while req is high; both are sampled only on the grant edge.
- SHIFT, once per cycle:
  - shift the word MSB-first into the history (new bit enters at [0]);
  - increment the bit counter.
- Window check: a window is compared only once at least 3 bits have been shifted. On a match (history == pattern):
  - the hit counter increments;
  - det is high the next cycle.
- Overlapping hits count: 10101 against pattern 101 counts 2.
- Hit counter saturation cannot occur given the CNT_W rule.
- Entering REPORT loads match_cnt and done_id from the internal values. done is high for the REPORT cycle.
- Reset (asserted at any time, including mid-SHIFT) forces:
  - state IDLE;
  - gnt, busy, det, done, done_id, match_cnt all 0;
  - history, counters and priority pointer cleared.
- The in-flight word is discarded and no done is produced for it.

## Timing
- Let T be the cycle in which req is seen high in IDLE.
- T+1: gnt pulses and busy rises; the SHIFT state covers cycles T+1..T+DATA_W.
- T+DATA_W+1: REPORT; done=1 and match_cnt is valid.
- T+DATA_W+2: IDLE, busy=0. The earliest next gnt is at T+DATA_W+3.
- Throughput is one word per DATA_W+2 cycles under continuous requests.
- A request that stays high through REPORT is re-evaluated in the next IDLE cycle together with the other requester, using the updated pointer.
- det lags the completing shift edge by one cycle. For a hit on the final bit, det is high in the REPORT cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then req=01, data0=8'b10101101, pat0=3'b101 -> gnt=01 at T+1; done at T+9 with match_cnt=3, done_id=0; det pulses 3 times.
- req=10, data1=8'h00, pat1=3'b000 -> match_cnt=6, done_id=1. Then data1=8'b11011011, pat1=3'b110 -> match_cnt=2.
- req=11 held continuously after reset -> grants alternate 01, 10, 01; consecutive gnt pulses are 10 cycles apart (DATA_W=8).
- data0=8'b01100000, pat0=3'b101 -> match_cnt=0, det never high; match_cnt from the previous done is held until this done.
- reset_n pulsed low during SHIFT cycle 4 -> all outputs 0 immediately; no done for the aborted word. A following req=11 grants requester 0 first.
- req toggled during SHIFT while data changes -> ignored. The result reflects the data sampled on the grant edge.
